// File: rtl/mem_access.sv
// Second memory sub-stage plus MEM/WB register: word-addressed data memory, 1-cycle registered result.
// A post-reset sweep zeroes every word while busy=1; stall holds the register, flush squashes it.
module mem_access #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              wre_in,
  input  logic              rde_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [4:0]        rd_in,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] mem_wb_rdata,
  output logic [DATA_W-1:0] mem_wb_alu,
  output logic [4:0]        mem_wb_rd,
  output logic              mem_wb_regwrite,
  output logic              mem_wb_memtoreg,
  output logic              mem_wb_valid
);

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [4:0]        rd;
    logic              regwrite;
    logic              memtoreg;
    logic              valid;
  } wb_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  wb_t               wb, wb_nxt, req;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Read sees pre-edge contents, so a store one cycle earlier is already visible.
  always_comb begin
    req          = '0;
    req.rdata    = rde_in ? mem[addr_in] : '0;
    req.alu      = alu_in;
    req.rd       = rd_in;
    req.regwrite = regwrite_in;
    req.memtoreg = memtoreg_in;
    req.valid    = valid_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      wb      <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      wb      <= wb_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    wb_nxt      = wb;
    mem_we      = 1'b0;
    mem_waddr   = addr_in;
    mem_wdata   = wdata_in;
    case (state)
      CLEAR: begin
        wb_nxt      = '0;
        mem_we      = 1'b1;
        mem_waddr   = clr_ptr;
        mem_wdata   = '0;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        if (flush) begin
          wb_nxt = '0;
        end else if (!stall) begin
          wb_nxt = req;
          // A simultaneous read request suppresses the store.
          mem_we = valid_in && wre_in && !rde_in;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign busy            = (state == CLEAR);
  assign mem_wb_rdata    = wb.rdata;
  assign mem_wb_alu      = wb.alu;
  assign mem_wb_rd       = wb.rd;
  assign mem_wb_regwrite = wb.regwrite;
  assign mem_wb_memtoreg = wb.memtoreg;
  assign mem_wb_valid    = wb.valid;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized traffic against an array-based reference model.
module tb_mem_access;

  localparam int DEPTH = 128;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  addr_in;
  logic        wre_in, rde_in;
  logic [31:0] wdata_in, alu_in;
  logic [4:0]  rd_in;
  logic        regwrite_in, memtoreg_in, valid_in, stall, flush;
  logic        busy;
  logic [31:0] mem_wb_rdata, mem_wb_alu;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite, mem_wb_memtoreg, mem_wb_valid;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] ref_mem [DEPTH];
  int          sweep_left = 0;
  logic [31:0] e_rdata = '0, e_alu = '0;
  logic [4:0]  e_rd = '0;
  logic        e_regwrite = 1'b0, e_memtoreg = 1'b0, e_valid = 1'b0, e_busy = 1'b1;

  mem_access dut (
    .clock(clock), .reset(reset), .addr_in(addr_in), .wre_in(wre_in), .rde_in(rde_in),
    .wdata_in(wdata_in), .alu_in(alu_in), .rd_in(rd_in), .regwrite_in(regwrite_in),
    .memtoreg_in(memtoreg_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .busy(busy), .mem_wb_rdata(mem_wb_rdata), .mem_wb_alu(mem_wb_alu), .mem_wb_rd(mem_wb_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_memtoreg(mem_wb_memtoreg), .mem_wb_valid(mem_wb_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // One clock edge; the model applies the behavioural rules with the inputs seen at that edge.
  task automatic cycle();
    @(posedge clock);
    if (reset) begin
      sweep_left = DEPTH;
      e_rdata = '0; e_alu = '0; e_rd = '0; e_regwrite = 0; e_memtoreg = 0; e_valid = 0;
    end else if (sweep_left > 0) begin
      ref_mem[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else if (flush) begin
      e_rdata = '0; e_alu = '0; e_rd = '0; e_regwrite = 0; e_memtoreg = 0; e_valid = 0;
    end else if (!stall) begin
      e_rdata    = rde_in ? ref_mem[addr_in] : 32'h0;
      e_alu      = alu_in;
      e_rd       = rd_in;
      e_regwrite = regwrite_in;
      e_memtoreg = memtoreg_in;
      e_valid    = valid_in;
      if (valid_in && wre_in && !rde_in) ref_mem[addr_in] = wdata_in;
    end
    e_busy = (sweep_left > 0);
    #1;
  endtask

  task automatic drive(input bit v, input bit w, input bit r, input logic [6:0] a,
                       input logic [31:0] wd, input bit st, input bit fl);
    valid_in = v; wre_in = w; rde_in = r; addr_in = a; wdata_in = wd;
    alu_in = $urandom; rd_in = 5'($urandom); regwrite_in = v; memtoreg_in = r;
    stall = st; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 7'd0, 32'h0, 0, 0);
  endtask

  // Holds reset for two edges, then counts how long busy stays high.
  task automatic reset_and_sweep(input string tag);
    int n;
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      cycle();
      vectors++;
      if (busy !== e_busy) begin
        miscompares++;
        $display("FAIL %s_busy_track: got %b expected %b at sweep cycle %0d", tag, busy, e_busy, n);
      end
    end
    vectors++;
    if (n != DEPTH) begin
      miscompares++;
      $display("FAIL %s_busy_len: busy high for %0d cycles expected %0d", tag, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    vectors++;
    if ({busy, mem_wb_valid, mem_wb_regwrite, mem_wb_memtoreg} !== 4'b1000 ||
        mem_wb_rdata !== 32'h0 || mem_wb_alu !== 32'h0 || mem_wb_rd !== 5'h0) begin
      miscompares++;
      $display("FAIL reset_values: got busy=%b valid=%b rdata=%h alu=%h rd=%h expected busy=1 all zero",
               busy, mem_wb_valid, mem_wb_rdata, mem_wb_alu, mem_wb_rd);
    end
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      // requests during the sweep must be ignored
      drive(1, 1, 0, 7'(n), 32'hFFFF_FFFF, 0, 0);
      n++;
      cycle();
      vectors++;
      if (busy === 1'b1 && mem_wb_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_hold: mem_wb_valid got %b expected 0 during sweep", mem_wb_valid);
      end
    end
    idle();
    vectors++;
    if (n != DEPTH) begin
      miscompares++;
      $display("FAIL busy_len: busy high for %0d cycles expected %0d", n, DEPTH);
    end
    foreach (ref_mem[i]) begin end
    for (int k = 0; k < 3; k++) begin
      logic [6:0] a;
      a = (k == 0) ? 7'd0 : (k == 1) ? 7'd64 : 7'd127;
      drive(1, 0, 1, a, 32'h0, 0, 0);
      cycle();
      vectors++;
      if (mem_wb_rdata !== 32'h0 || mem_wb_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL cleared_read_%0d: got rdata=%h valid=%b expected 00000000 valid=1",
                 a, mem_wb_rdata, mem_wb_valid);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_store_load();
    drive(1, 1, 0, 7'd5, 32'hDEADBEEF, 0, 0);
    cycle();
    drive(1, 0, 1, 7'd5, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'hDEADBEEF || mem_wb_memtoreg !== 1'b1 || mem_wb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL store_load: got rdata=%h memtoreg=%b valid=%b expected deadbeef 1 1",
               mem_wb_rdata, mem_wb_memtoreg, mem_wb_valid);
    end
    vectors++;
    if (mem_wb_alu !== e_alu || mem_wb_rd !== e_rd) begin
      miscompares++;
      $display("FAIL passthrough: got alu=%h rd=%h expected alu=%h rd=%h", mem_wb_alu, mem_wb_rd, e_alu, e_rd);
    end
    idle();
    cycle();
  endtask

  task automatic test_stall();
    logic [31:0] held_alu;
    held_alu = e_alu;
    drive(1, 1, 0, 7'd9, 32'h11111111, 1, 0);
    cycle();
    vectors++;
    if (mem_wb_alu !== held_alu || mem_wb_valid !== e_valid) begin
      miscompares++;
      $display("FAIL stall_hold: got alu=%h valid=%b expected alu=%h valid=%b",
               mem_wb_alu, mem_wb_valid, held_alu, e_valid);
    end
    drive(1, 0, 1, 7'd9, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL stalled_store: got %h expected 00000000", mem_wb_rdata);
    end
    drive(1, 1, 0, 7'd9, 32'h11111111, 0, 0);
    cycle();
    drive(1, 0, 1, 7'd9, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h11111111) begin
      miscompares++;
      $display("FAIL represented_store: got %h expected 11111111", mem_wb_rdata);
    end
    idle();
    cycle();
  endtask

  task automatic test_flush();
    drive(1, 1, 0, 7'd3, 32'hA5A5A5A5, 1, 1);
    cycle();
    vectors++;
    if (mem_wb_valid !== 1'b0 || mem_wb_regwrite !== 1'b0 || mem_wb_alu !== 32'h0) begin
      miscompares++;
      $display("FAIL flush_clear: got valid=%b regwrite=%b alu=%h expected 0 0 00000000",
               mem_wb_valid, mem_wb_regwrite, mem_wb_alu);
    end
    drive(1, 0, 1, 7'd3, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL flush_no_write: got %h expected 00000000", mem_wb_rdata);
    end
    idle();
    cycle();
  endtask

  task automatic test_conflict();
    drive(1, 1, 0, 7'd7, 32'h0000_0777, 0, 0);
    cycle();
    drive(1, 1, 1, 7'd7, 32'h0BAD_0BAD, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h0000_0777) begin
      miscompares++;
      $display("FAIL conflict_read: got %h expected 00000777", mem_wb_rdata);
    end
    drive(1, 0, 1, 7'd7, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h0000_0777) begin
      miscompares++;
      $display("FAIL conflict_no_write: got %h expected 00000777", mem_wb_rdata);
    end
    idle();
    cycle();
  endtask

  task automatic test_reset_mid_sweep();
    drive(1, 1, 0, 7'd60, 32'h5, 0, 0);
    cycle();
    drive(1, 0, 1, 7'd60, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h5) begin
      miscompares++;
      $display("FAIL pre_sweep_value: got %h expected 00000005", mem_wb_rdata);
    end
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 60; i++) cycle();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_sweep_busy: got %b expected 1", busy);
    end
    reset_and_sweep("restart");
    drive(1, 0, 1, 7'd60, 32'h0, 0, 0);
    cycle();
    vectors++;
    if (mem_wb_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL restart_cleared: got %h expected 00000000", mem_wb_rdata);
    end
    idle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            7'($urandom_range(0, 15)), $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      cycle();
      vectors++;
      if ({mem_wb_rdata, mem_wb_alu, mem_wb_rd, mem_wb_regwrite, mem_wb_memtoreg, mem_wb_valid, busy} !==
          {e_rdata, e_alu, e_rd, e_regwrite, e_memtoreg, e_valid, e_busy}) begin
        miscompares++;
        $display("FAIL random_%0d: got rdata=%h alu=%h rd=%h rw=%b mt=%b v=%b busy=%b expected %h %h %h %b %b %b %b",
                 i, mem_wb_rdata, mem_wb_alu, mem_wb_rd, mem_wb_regwrite, mem_wb_memtoreg, mem_wb_valid, busy,
                 e_rdata, e_alu, e_rd, e_regwrite, e_memtoreg, e_valid, e_busy);
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_store_load();
    test_stall();
    test_flush();
    test_conflict();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
